// File: rtl/alu_sequencer_if.sv
// Bundle between the ALU sequencer and its surroundings: program load port,
// run control, ALU command/result path and status.
interface alu_sequencer_if #(
  parameter int unsigned PC_W = 5
);
  logic            load_valid;
  logic [19:0]     load_data;
  logic            load_ready;
  logic            clear;
  logic            start;
  logic            busy;
  logic            done;
  logic [3:0]      alu_op_code;
  logic [15:0]     alu_inputA;
  logic [31:0]     alu_R;
  logic            alu_error;
  logic [31:0]     acc;
  logic [1:0]      err_flags;
  logic [PC_W-1:0] pc;

  // Sequencer side
  modport slave (
    input  load_valid, load_data, clear, start, alu_R, alu_error,
    output load_ready, busy, done, alu_op_code, alu_inputA, acc, err_flags, pc
  );

  // Program loader / ALU side
  modport master (
    output load_valid, load_data, clear, start, alu_R, alu_error,
    input  load_ready, busy, done, alu_op_code, alu_inputA, acc, err_flags, pc
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command initiator for the breadboard ALU: stores a small {op_code, operand}
// program, issues it entry by entry and accumulates the ALU results.
module alu_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter bit          HALT_ON_ERROR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PC_W    = AW + 1;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ACC_W   = 32;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_MOD = 4'd1;
  localparam logic [OP_W-1:0] OP_DIV = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd8;
  localparam logic [OP_W-1:0] OP_NOP = 4'b1101;

  typedef struct packed {
    logic [OP_W-1:0]   op_code;
    logic [DATA_W-1:0] operand;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     count_q, count_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          err_new;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load_ready_c;
  logic                mem_we;
  entry_t              cur_entry;
  entry_t              mem [DEPTH];

  // Program storage; contents are meaningless beyond count, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= entry_t'(bus.load_data);
    end
  end

  assign cur_entry = mem[pc_q[AW-1:0]];

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    err_d        = err_q;
    err_new      = 2'b00;
    op_d         = op_q;
    a_d          = a_q;
    mem_we       = 1'b0;
    load_ready_c = (state_q == S_IDLE) && (count_q < PC_W'(DEPTH)) && !bus.start;

    case (state_q)
      S_IDLE: begin
        // clear beats start, so a combined clear+start runs an empty program
        if (bus.clear) begin
          count_d = '0;
          if (bus.start) begin
            state_d = S_DONE;
          end
        end else if (bus.start) begin
          if (count_q != '0) begin
            pc_d    = '0;
            err_d   = 2'b00;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else if (bus.load_valid && load_ready_c) begin
          mem_we  = 1'b1;
          count_d = count_q + PC_W'(1);
        end
      end

      S_FETCH: begin
        op_d    = cur_entry.op_code;
        a_d     = cur_entry.operand;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        acc_d = bus.alu_R;
        // Divide-by-zero is judged on the divisor the ALU saw this cycle
        if (((op_q == OP_MOD) || (op_q == OP_DIV)) && (acc_q[DATA_W-1:0] == '0)) begin
          err_new[1] = 1'b1;
        end
        if (((op_q == OP_ADD) || (op_q == OP_SUB)) && bus.alu_error) begin
          err_new[0] = 1'b1;
        end
        err_d = err_q | err_new;
        pc_d  = pc_q + PC_W'(1);
        if ((pc_d == count_q) || (HALT_ON_ERROR && (err_new != 2'b00))) begin
          state_d = S_DONE;
          op_d    = OP_NOP;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        op_d    = OP_NOP;
        state_d = S_IDLE;
      end

      default: begin
        op_d    = OP_NOP;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      err_q   <= 2'b00;
      op_q    <= OP_NOP;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      op_q    <= op_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready  = load_ready_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.alu_op_code = op_q;
  assign bus.alu_inputA  = a_q;
  assign bus.acc         = acc_q;
  assign bus.err_flags   = err_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural breadboard ALU and
// an expected-accumulator scoreboard.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];

  alu_sequencer_if #(.PC_W(5)) bus ();

  alu_sequencer #(
    .DEPTH         (16),
    .HALT_ON_ERROR (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Breadboard ALU: A = operand, B = acc[15:0], NO-OP passes acc through
  logic [15:0] m_a, m_b, m_sum, m_diff;
  always_comb begin
    m_a           = bus.alu_inputA;
    m_b           = bus.acc[15:0];
    m_sum         = m_a + m_b;
    m_diff        = m_a - m_b;
    bus.alu_R     = bus.acc;
    bus.alu_error = 1'b0;
    case (bus.alu_op_code)
      4'd0: begin
        bus.alu_R     = {16'h0, m_sum};
        bus.alu_error = (m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]);
      end
      4'd1: bus.alu_R = (m_b == 16'h0) ? 32'hFFFF_FFFF : {16'h0, m_a % m_b};
      4'd2: bus.alu_R = (m_b == 16'h0) ? 32'hFFFF_FFFF : {16'h0, m_a / m_b};
      4'd3: bus.alu_R = {16'h0, m_a};
      4'd4: bus.alu_R = 32'(m_a) * 32'(m_b);
      4'd8: begin
        bus.alu_R     = {16'h0, m_diff};
        bus.alu_error = (m_a[15] != m_b[15]) && (m_diff[15] != m_a[15]);
      end
      default: bus.alu_R = bus.acc;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [3:0] op, input logic [15:0] operand);
    bus.load_valid = 1'b1;
    bus.load_data  = {op, operand};
    #1;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready op=%0d got %b want 1", op, bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic clear_prog();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Start a run and check busy/done timing plus every accumulator step
  task automatic run_prog(input string name, input logic with_clear, input logic with_load,
                          input logic [1:0] exp_err, input logic [4:0] exp_pc);
    int m;
    logic [31:0] exp_acc;
    m = exp_q.size();
    bus.start      = 1'b1;
    bus.clear      = with_clear;
    bus.load_valid = with_load;
    bus.load_data  = {4'd3, 16'hBEEF};
    tick();
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    for (int j = 0; j <= 2 * m; j++) begin
      if (j > 0) tick();
      if ((j > 0) && (j % 2 == 0)) begin
        exp_acc = exp_q.pop_front();
        checks++;
        if (bus.acc !== exp_acc) begin
          errors++;
          $display("FAIL %s acc step %0d got %h want %h", name, j / 2, bus.acc, exp_acc);
        end
      end
      checks++;
      if (j < 2 * m) begin
        if ({bus.busy, bus.done} !== 2'b10) begin
          errors++;
          $display("FAIL %s busy/done cycle %0d got %b want 10", name, j, {bus.busy, bus.done});
        end
      end else begin
        if ({bus.busy, bus.done, bus.alu_op_code} !== {2'b01, 4'hD}) begin
          errors++;
          $display("FAIL %s done cycle %0d busy/done/op got %b want 011101", name, j,
                   {bus.busy, bus.done, bus.alu_op_code});
        end
      end
    end
    checks++;
    if (bus.pc !== exp_pc) begin
      errors++;
      $display("FAIL %s pc got %0d want %0d", name, bus.pc, exp_pc);
    end
    checks++;
    if (bus.err_flags !== exp_err) begin
      errors++;
      $display("FAIL %s err_flags got %b want %b", name, bus.err_flags, exp_err);
    end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL %s after done busy/done got %b want 00", name, {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.load_ready, bus.err_flags, bus.alu_op_code} !== 9'b0_0_1_00_1101) begin
      errors++;
      $display("FAIL reset ctrl got %b want 001001101",
               {bus.busy, bus.done, bus.load_ready, bus.err_flags, bus.alu_op_code});
    end
    checks++;
    if ({bus.acc, bus.pc, bus.alu_inputA} !== 53'd0) begin
      errors++;
      $display("FAIL reset data acc=%h pc=%0d A=%h want 0", bus.acc, bus.pc, bus.alu_inputA);
    end
  endtask

  task automatic load_basic();
    load_entry(4'd3, 16'd0);
    load_entry(4'd0, 16'd6);
    load_entry(4'd4, 16'd6);
    load_entry(4'd8, 16'd40);
    load_entry(4'd2, 16'd20);
  endtask

  task automatic test_basic_program();
    clear_prog();
    load_basic();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd36);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd5);
    run_prog("basic", 1'b0, 1'b0, 2'b00, 5'd5);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd36);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd5);
    run_prog("rerun", 1'b0, 1'b0, 2'b00, 5'd5);
  endtask

  task automatic test_halt_div0();
    clear_prog();
    load_entry(4'd3, 16'd0);
    load_entry(4'd2, 16'd5);
    load_entry(4'd0, 16'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    run_prog("halt_div0", 1'b0, 1'b0, 2'b10, 5'd2);
    checks++;
    if ({bus.acc, bus.alu_inputA} !== {32'hFFFF_FFFF, 16'd5}) begin
      errors++;
      $display("FAIL halt_div0 third entry issued acc=%h A=%h want ffffffff/0005",
               bus.acc, bus.alu_inputA);
    end
  endtask

  task automatic test_overflow();
    clear_prog();
    load_entry(4'd3, 16'h7FFF);
    load_entry(4'd0, 16'h0001);
    exp_q.push_back(32'h0000_7FFF);
    exp_q.push_back(32'h0000_8000);
    run_prog("overflow", 1'b0, 1'b0, 2'b01, 5'd2);
  endtask

  task automatic test_full_load();
    logic want_rdy;
    clear_prog();
    for (int i = 0; i < 17; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = {4'd3, 16'(i)};
      want_rdy       = (i < 16);
      #1;
      checks++;
      if (bus.load_ready !== want_rdy) begin
        errors++;
        $display("FAIL full_load offer %0d load_ready got %b want %b", i, bus.load_ready, want_rdy);
      end
      if (i < 16) exp_q.push_back(32'(i));
      tick();
    end
    bus.load_valid = 1'b0;
    run_prog("full", 1'b0, 1'b0, 2'b00, 5'd16);
  endtask

  task automatic test_collisions();
    clear_prog();
    run_prog("start_vs_load", 1'b0, 1'b1, 2'b00, 5'd16);
    run_prog("after_start_vs_load", 1'b0, 1'b0, 2'b00, 5'd16);
    load_entry(4'd3, 16'h1234);
    run_prog("clear_vs_start", 1'b1, 1'b0, 2'b00, 5'd16);
    run_prog("empty", 1'b0, 1'b0, 2'b00, 5'd16);
    checks++;
    if (bus.acc !== 32'd15) begin
      errors++;
      $display("FAIL empty acc got %h want 0000000f", bus.acc);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    load_basic();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({bus.busy, bus.acc} !== {1'b1, 32'd6}) begin
      errors++;
      $display("FAIL midrun pre-reset busy/acc got %b/%h want 1/00000006", bus.busy, bus.acc);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.load_ready, bus.err_flags, bus.alu_op_code} !== 9'b0_0_1_00_1101) begin
      errors++;
      $display("FAIL midrun reset ctrl got %b want 001001101",
               {bus.busy, bus.done, bus.load_ready, bus.err_flags, bus.alu_op_code});
    end
    checks++;
    if ({bus.acc, bus.pc, bus.alu_inputA} !== 53'd0) begin
      errors++;
      $display("FAIL midrun reset data acc=%h pc=%0d A=%h want 0", bus.acc, bus.pc, bus.alu_inputA);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_prog("post_reset", 1'b0, 1'b0, 2'b00, 5'd0);
    checks++;
    if ({bus.acc, bus.alu_op_code} !== {32'd0, 4'hD}) begin
      errors++;
      $display("FAIL post_reset acc/op got %h/%h want 00000000/d", bus.acc, bus.alu_op_code);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_program();
    test_back_to_back();
    test_halt_div0();
    test_overflow();
    test_full_load();
    test_collisions();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
